// File: rtl/ros2_rx_msg_reader_if.sv
// Bundle of the subscriber write port, buffer-ownership handshake and output byte
// stream around ros2_rx_msg_reader.
interface ros2_rx_msg_reader_if #(
  parameter int AW = 6
);
  logic [AW-1:0] wr_addr;
  logic          wr_ce;
  logic          wr_we;
  logic [7:0]    wr_wdata;
  logic [7:0]    rx_len;
  logic          cpu_req;
  logic          cpu_grant;
  logic          cpu_rel;
  logic          m_valid;
  logic          m_ready;
  logic [7:0]    m_data;
  logic          m_last;
  logic [15:0]   msg_count;
  logic          protocol_err;

  // slave: the reader block itself
  modport slave (
    input  wr_addr, wr_ce, wr_we, wr_wdata, rx_len, cpu_grant, m_ready,
    output cpu_req, cpu_rel, m_valid, m_data, m_last, msg_count, protocol_err
  );

  // master: subscriber core plus downstream consumer
  modport master (
    output wr_addr, wr_ce, wr_we, wr_wdata, rx_len, cpu_grant, m_ready,
    input  cpu_req, cpu_rel, m_valid, m_data, m_last, msg_count, protocol_err
  );
endinterface

// File: rtl/ros2_rx_msg_reader.sv
// Owns the ROS2 subscriber message RAM and drains each new message as a byte
// stream under the cpu_req/grant/rel buffer-ownership handshake.
//
// state  | meaning
// IDLE   | waiting for a write to mark the buffer dirty
// REQ    | cpu_req high, waiting for cpu_grant
// READ   | streaming bytes 0..len-1 on the valid/ready port
// REL    | issuing the one-cycle cpu_rel pulse and bumping msg_count
module ros2_rx_msg_reader #(
  parameter int MAX_LEN = 64,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input logic                 clk,
  input logic                 rst,
  ros2_rx_msg_reader_if.slave bus
);

  localparam int         IW        = $clog2(MAX_LEN);
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [7:0]  mem [MAX_LEN];
  logic [1:0]  state;
  logic        dirty;
  logic        prime;
  logic [8:0]  len;
  logic [8:0]  rd_ptr;
  logic [8:0]  rx_len_clip;
  logic        wr_hit;
  logic        addr_ok;
  logic        grant_take;
  logic        hs;

  logic        cpu_req;
  logic        cpu_rel;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] msg_count;
  logic        protocol_err;

  assign wr_hit      = bus.wr_ce & bus.wr_we;
  assign grant_take  = (state == S_REQ) & bus.cpu_grant;
  assign hs          = m_valid & bus.m_ready;
  assign rx_len_clip = ({1'b0, bus.rx_len} > MAX_LEN_W) ? MAX_LEN_W : {1'b0, bus.rx_len};

  // Out-of-range addresses can only exist when the address bus is wider than the RAM.
  if ((2 ** AW) > MAX_LEN) begin : g_addr_chk
    assign addr_ok = (32'(bus.wr_addr) < MAX_LEN);
  end else begin : g_addr_full
    assign addr_ok = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_hit && addr_ok) mem[bus.wr_addr[IW-1:0]] <= bus.wr_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      dirty        <= 1'b0;
      prime        <= 1'b0;
      len          <= '0;
      rd_ptr       <= '0;
      cpu_req      <= 1'b0;
      cpu_rel      <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      msg_count    <= '0;
      protocol_err <= 1'b0;
    end else begin
      // A write racing the grant keeps dirty set so the message is re-read.
      dirty <= wr_hit | (dirty & ~grant_take);
      if (wr_hit && (state == S_READ || state == S_REL)) protocol_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (dirty) begin
            cpu_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.cpu_grant) begin
            len    <= rx_len_clip;
            rd_ptr <= '0;
            prime  <= 1'b1;
            state  <= (rx_len_clip == 9'd0) ? S_REL : S_READ;
          end
        end
        S_READ: begin
          // prime spends one cycle so m_valid rises two edges after the grant edge
          if (prime) begin
            prime <= 1'b0;
          end else if (hs && m_last) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            cpu_rel   <= 1'b1;
            cpu_req   <= 1'b0;
            msg_count <= msg_count + 16'd1;
            state     <= S_REL;
          end else if ((!m_valid || bus.m_ready) && (rd_ptr < len)) begin
            m_data  <= mem[rd_ptr[IW-1:0]];
            m_valid <= 1'b1;
            m_last  <= (rd_ptr == len - 9'd1);
            rd_ptr  <= rd_ptr + 9'd1;
          end
        end
        S_REL: begin
          // Arriving from READ the pulse is already out; the empty-message path raises it here.
          if (cpu_rel) begin
            cpu_rel <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cpu_rel   <= 1'b1;
            cpu_req   <= 1'b0;
            msg_count <= msg_count + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_req      = cpu_req;
  assign bus.cpu_rel      = cpu_rel;
  assign bus.m_valid      = m_valid;
  assign bus.m_data       = m_data;
  assign bus.m_last       = m_last;
  assign bus.msg_count    = msg_count;
  assign bus.protocol_err = protocol_err;

endmodule

// File: doc/ros2_rx_msg_reader.md
# ros2_rx_msg_reader

Drains the ROS2 subscriber receive-message buffer as a byte stream. The block owns the message RAM written through the subscriber's `ros2_app_rx_data_*` write port. Once a new message has landed, it acquires the buffer with the `ros2_app_rx_data_cpu_req/grant/rel` handshake, streams `ros2_app_rx_data_len` bytes out on a valid/ready interface, then releases the buffer. It sits between `ros2_ether` and application logic (UART bridge, LED/actuator decoders, soft-CPU FIFO).

## Interface
Parameters:
- `MAX_LEN`, default 64: message RAM depth in bytes; equals `ROS2_MAX_APP_DATA_LEN`.
- `AW`, default `$clog2(MAX_LEN)`: write address width.

Ports:
- `clk` in 1: the single clock; all logic is synchronous to its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_addr` in AW: subscriber write address.
- `wr_ce` in 1: subscriber write chip enable.
- `wr_we` in 1: subscriber write enable.
- `wr_wdata` in 8: subscriber write byte.
- `rx_len` in 8: received message length from `ros2_app_rx_data_len`.
- `cpu_req` out 1: buffer ownership request, level signal.
- `cpu_grant` in 1: ownership granted by the ROS2 core.
- `cpu_rel` out 1: one-cycle release pulse.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: downstream ready.
- `m_data` out 8: output byte.
- `m_last` out 1: asserted with the final byte of a message.
- `msg_count` out 16: number of messages fully drained; wraps 0xFFFF→0.
- `protocol_err` out 1: sticky flag; a subscriber write occurred while the block held the grant.

## Operation
- A write occurs when `wr_ce & wr_we`. The byte is stored at `wr_addr`. Writes with `wr_addr >= MAX_LEN` are dropped. Every write, including a dropped one, sets the `dirty` flag.
- Message length is latched at grant as `len = min(rx_len, MAX_LEN)`.
- State machine:
  - IDLE → REQ when `dirty` is set.
  - REQ: `cpu_req`=1. When `cpu_grant` is sampled high, latch `len` and clear `dirty`. Go to READ if `len`≠0, otherwise go to REL.
  - READ: emit bytes at addresses 0..len-1 in order. Advance on each `m_valid & m_ready` handshake. After the handshake on the byte with `m_last`, go to REL.
  - REL: `cpu_rel`=1 for exactly one cycle, `cpu_req`=0, `msg_count`+1. Then return to IDLE.
- `cpu_grant` is sampled only in REQ. A grant drop during READ is ignored and the read completes.
- A write in the same cycle as the grant is latched leaves `dirty` set, because set wins over clear. The block then re-reads after REL.
- A write while in READ or REL stores the byte, sets `dirty`, and sets `protocol_err`. The stream in progress is not aborted.
- AXI-style stream rules:
  - While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable.
  - `m_valid` never drops without a handshake.
- The message RAM is not cleared by reset.

## Timing
- Reset values: `cpu_req`=0, `cpu_rel`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `msg_count`=0, `protocol_err`=0, `dirty`=0, state IDLE.
- `cpu_req` rises on the first edge after `dirty` is set while in IDLE.
- RAM read is synchronous with 1-cycle latency. `m_valid` rises exactly 2 edges after the edge that samples `cpu_grant`=1.
- With `m_ready` held high, `len` bytes appear on `len` consecutive cycles. There are no bubbles, including after a stall ends.
- `cpu_rel` pulses on the edge after the final handshake. `cpu_req` falls on that same edge. `msg_count` updates on that same edge.
- The `len`=0 path:
  - Grant edge → next edge: `cpu_rel` pulse.
  - No `m_valid` is emitted.
  - `msg_count` still increments.
- Reset asserted mid-operation:
  - All outputs go immediately to their reset values.
  - A partially sent message is discarded.
  - `cpu_req` drops, and no `cpu_rel` is issued.

## Test plan
- Write "hello" at addresses 0-4, `rx_len`=5, grant 3 cycles after `cpu_req`, `m_ready`=1 → bytes 68 65 6C 6C 6F on 5 consecutive cycles starting 2 cycles after the grant; `m_last` only on 6F; one `cpu_rel` pulse; `msg_count`=1.
- Same message with `m_ready` toggling 1,0,0,1,… → bytes unchanged and in order; data stable while stalled; no duplicates or gaps.
- `rx_len`=0 after a write → `cpu_req`, then grant, then `cpu_rel` one cycle later; `m_valid` never asserted; `msg_count` increments.
- `rx_len`=200 with `MAX_LEN`=64; write to address 70 → exactly 64 bytes output, `m_last` on address 63; the write to 70 is dropped but `dirty` is set.
- Write during READ → the current stream completes; `protocol_err`=1 and stays set; a second REQ follows the REL.
- Assert `rst` for 1 cycle on the 3rd output byte → all outputs 0 immediately; no `cpu_rel`; `msg_count`=0; the block stays IDLE until the next write.
